// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the branch prediction path.
//   - 2-bit saturating counter encodings and the allocation value
//   - default PC width (PCs are word addresses)
//   - saturating increment/decrement helpers for the 2-bit counters
package cpu_pkg;

  localparam int PC_W_DEFAULT = 32;

  localparam logic [1:0] CTR_SNT   = 2'b00;  // strong not-taken
  localparam logic [1:0] CTR_WNT   = 2'b01;  // weak not-taken
  localparam logic [1:0] CTR_WT    = 2'b10;  // weak taken
  localparam logic [1:0] CTR_ST    = 2'b11;  // strong taken
  localparam logic [1:0] CTR_ALLOC = CTR_WT; // fresh entries start weakly taken

  // Counters saturate at the ends; they never wrap.
  function automatic logic [1:0] sat_inc2(input logic [1:0] ctr);
    return (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec2(input logic [1:0] ctr);
    return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/bp_stats.sv
// Prediction statistics for the on-board display.
// Ports:
//   clk        system clock
//   srst       synchronous active-high reset, clears both counters
//   en         a control instruction resolved this cycle
//   hit        that instruction was predicted correctly
//   cnt_branch number of resolved control instructions (wraps)
//   cnt_hit    number of correctly predicted ones (wraps)
module bp_stats (
  input  logic        clk,
  input  logic        srst,
  input  logic        en,
  input  logic        hit,
  output logic [31:0] cnt_branch,
  output logic [31:0] cnt_hit
);

  logic [31:0] cnt_branch_reg;
  logic [31:0] cnt_hit_reg;
  logic [31:0] cnt_branch_next;
  logic [31:0] cnt_hit_next;

  always_comb begin
    cnt_branch_next = cnt_branch_reg;
    cnt_hit_next    = cnt_hit_reg;
    if (en) begin
      cnt_branch_next = cnt_branch_reg + 32'd1;
      if (hit) begin
        cnt_hit_next = cnt_hit_reg + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      cnt_branch_reg <= 32'd0;
      cnt_hit_reg    <= 32'd0;
    end else begin
      cnt_branch_reg <= cnt_branch_next;
      cnt_hit_reg    <= cnt_hit_next;
    end
  end

  assign cnt_branch = cnt_branch_reg;
  assign cnt_hit    = cnt_hit_reg;

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped BTB with a 2-bit saturating
// counter per entry, trained from EX, with misprediction detection and
// prediction statistics.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   halt            CPU halted: freezes table and statistics
//   pc_if           PC being fetched
//   pred_taken      predicted taken (hit and counter MSB set)
//   pred_target     predicted next PC (stored target or pc_if+1)
//   ex_valid        EX holds a real branch/jump
//   ex_pc           PC of the EX instruction
//   ex_taken        resolved direction
//   ex_target       resolved target
//   ex_pred_taken   prediction made for this instruction at fetch
//   ex_pred_target  predicted target made for this instruction at fetch
//   mispredict      flush request
//   fix_pc          PC to refetch on a flush
//   cnt_branch      resolved control instructions
//   cnt_hit         correctly predicted control instructions
module branch_predictor
  import cpu_pkg::*;
#(
  parameter int IDX_W = 3,
  parameter int PC_W  = PC_W_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            halt,
  input  logic [PC_W-1:0] pc_if,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_target,
  input  logic            ex_valid,
  input  logic [PC_W-1:0] ex_pc,
  input  logic            ex_taken,
  input  logic [PC_W-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [PC_W-1:0] ex_pred_target,
  output logic            mispredict,
  output logic [PC_W-1:0] fix_pc,
  output logic [31:0]     cnt_branch,
  output logic [31:0]     cnt_hit
);

  localparam int DEPTH = 1 << IDX_W;
  localparam int TAG_W = PC_W - IDX_W;

  // Flattened views of the per-entry registers for the read ports.
  logic [DEPTH-1:0]                 valid_vec;
  logic [DEPTH-1:0][TAG_W-1:0]      tag_vec;
  logic [DEPTH-1:0][PC_W-1:0]       target_vec;
  logic [DEPTH-1:0][1:0]            ctr_vec;

  // Fetch-side lookup (combinational, reads pre-edge contents).
  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  logic             if_hit;

  assign if_idx = pc_if[IDX_W-1:0];
  assign if_tag = pc_if[PC_W-1:IDX_W];
  assign if_hit = valid_vec[if_idx] && (tag_vec[if_idx] == if_tag);

  assign pred_taken  = if_hit && ctr_vec[if_idx][1];
  assign pred_target = pred_taken ? target_vec[if_idx] : pc_if + PC_W'(1);

  // EX-side lookup used for training.
  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] ex_tag;
  logic             ex_hit;
  logic             ex_active;
  logic             wr_en;
  logic [1:0]       ctr_next;
  logic [PC_W-1:0]  target_next;

  assign ex_idx    = ex_pc[IDX_W-1:0];
  assign ex_tag    = ex_pc[PC_W-1:IDX_W];
  assign ex_hit    = valid_vec[ex_idx] && (tag_vec[ex_idx] == ex_tag);
  assign ex_active = ex_valid && !halt;

  // A not-taken miss leaves the table alone; everything else writes the slot.
  assign wr_en = ex_active && (ex_hit || ex_taken);

  always_comb begin
    ctr_next    = CTR_ALLOC;
    target_next = ex_target;
    if (ex_hit) begin
      if (ex_taken) begin
        ctr_next    = sat_inc2(ctr_vec[ex_idx]);
        target_next = ex_target;
      end else begin
        ctr_next    = sat_dec2(ctr_vec[ex_idx]);
        target_next = target_vec[ex_idx];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic             valid_reg;
      logic [TAG_W-1:0] tag_reg;
      logic [PC_W-1:0]  target_reg;
      logic [1:0]       ctr_reg;

      // Tag and target carry no reset: they are ignored while valid is low.
      always_ff @(posedge clk) begin
        if (rst) begin
          valid_reg <= 1'b0;
          ctr_reg   <= CTR_SNT;
        end else if (wr_en && (ex_idx == IDX_W'(gi))) begin
          valid_reg  <= 1'b1;
          tag_reg    <= ex_tag;
          target_reg <= target_next;
          ctr_reg    <= ctr_next;
        end
      end

      assign valid_vec[gi]  = valid_reg;
      assign tag_vec[gi]    = tag_reg;
      assign target_vec[gi] = target_reg;
      assign ctr_vec[gi]    = ctr_reg;
    end
  endgenerate

  // Wrong direction, or right "taken" guess to the wrong place.
  assign mispredict = ex_active &&
                      ((ex_taken != ex_pred_taken) ||
                       (ex_taken && ex_pred_taken && (ex_target != ex_pred_target)));
  assign fix_pc     = ex_taken ? ex_target : ex_pc + PC_W'(1);

  bp_stats u_stats (
    .clk        (clk),
    .srst       (rst),
    .en         (ex_active),
    .hit        (!mispredict),
    .cnt_branch (cnt_branch),
    .cnt_hit    (cnt_hit)
  );

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  logic        clk;
  logic        rst;
  logic        halt;
  logic [31:0] pc_if;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        mispredict;
  logic [31:0] fix_pc;
  logic [31:0] cnt_branch;
  logic [31:0] cnt_hit;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_branch = 32'd0;
  logic [31:0] exp_hit    = 32'd0;

  branch_predictor #(.IDX_W(3), .PC_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .halt           (halt),
    .pc_if          (pc_if),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
    .ex_taken       (ex_taken),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .mispredict     (mispredict),
    .fix_pc         (fix_pc),
    .cnt_branch     (cnt_branch),
    .cnt_hit        (cnt_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one EX-stage transaction (inputs change just after a negedge).
  task automatic ex_set(input logic v, input logic [31:0] pc, input logic tk,
                        input logic [31:0] tg, input logic ptk, input logic [31:0] ptg);
    ex_valid       = v;
    ex_pc          = pc;
    ex_taken       = tk;
    ex_target      = tg;
    ex_pred_taken  = ptk;
    ex_pred_target = ptg;
    $display("ex: valid=%0b halt=%0b rst=%0b pc=%h taken=%0b target=%h pred_taken=%0b pred_target=%h",
             v, halt, rst, pc, tk, tg, ptk, ptg);
  endtask

  // Pass one rising edge, return just after the following negedge with EX idle.
  task automatic tick;
    @(negedge clk);
    ex_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pc_if = 32'h10;
    #1;
    n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL reset_pred_taken: got %0b want 0", pred_taken); end
    n_cmp++; if (pred_target !== 32'h11) begin n_err++; $display("FAIL reset_pred_target: got %h want 00000011", pred_target); end
    n_cmp++; if (cnt_branch !== 32'd0) begin n_err++; $display("FAIL reset_cnt_branch: got %h want 0", cnt_branch); end
    n_cmp++; if (cnt_hit !== 32'd0) begin n_err++; $display("FAIL reset_cnt_hit: got %h want 0", cnt_hit); end
    n_cmp++; if (mispredict !== 1'b0) begin n_err++; $display("FAIL reset_mispredict: got %0b want 0", mispredict); end
  endtask

  task automatic test_allocate;
    pc_if = 32'h10;
    ex_set(1'b1, 32'h10, 1'b1, 32'h40, 1'b0, 32'h11);
    #1;
    n_cmp++; if (mispredict !== 1'b1) begin n_err++; $display("FAIL alloc_mispredict: got %0b want 1", mispredict); end
    n_cmp++; if (fix_pc !== 32'h40) begin n_err++; $display("FAIL alloc_fix_pc: got %h want 00000040", fix_pc); end
    // same-index lookup during training sees the old (empty) contents
    n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL alloc_no_bypass: got %0b want 0", pred_taken); end
    tick;
    exp_branch = exp_branch + 1;
    n_cmp++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL alloc_pred_taken: got %0b want 1", pred_taken); end
    n_cmp++; if (pred_target !== 32'h40) begin n_err++; $display("FAIL alloc_pred_target: got %h want 00000040", pred_target); end
    n_cmp++; if (cnt_branch !== exp_branch) begin n_err++; $display("FAIL alloc_cnt_branch: got %h want %h", cnt_branch, exp_branch); end
    n_cmp++; if (cnt_hit !== exp_hit) begin n_err++; $display("FAIL alloc_cnt_hit: got %h want %h", cnt_hit, exp_hit); end
  endtask

  task automatic test_counter;
    logic [4:0] before_pred;
    logic [4:0] after_pred;
    pc_if = 32'h10;
    // 10 -> 01: predicted taken, resolved not-taken
    ex_set(1'b1, 32'h10, 1'b0, 32'h40, 1'b1, 32'h40);
    #1;
    n_cmp++; if (mispredict !== 1'b1) begin n_err++; $display("FAIL nt1_mispredict: got %0b want 1", mispredict); end
    n_cmp++; if (fix_pc !== 32'h11) begin n_err++; $display("FAIL nt1_fix_pc: got %h want 00000011", fix_pc); end
    tick;
    exp_branch = exp_branch + 1;
    n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL nt1_pred_taken: got %0b want 0", pred_taken); end
    n_cmp++; if (pred_target !== 32'h11) begin n_err++; $display("FAIL nt1_pred_target: got %h want 00000011", pred_target); end
    // 01 -> 00, then 00 stays 00; both correctly predicted
    for (int i = 0; i < 2; i++) begin
      ex_set(1'b1, 32'h10, 1'b0, 32'h40, 1'b0, 32'h11);
      #1;
      n_cmp++; if (mispredict !== 1'b0) begin n_err++; $display("FAIL nt%0d_mispredict: got %0b want 0", i + 2, mispredict); end
      tick;
      exp_branch = exp_branch + 1;
      exp_hit    = exp_hit + 1;
      n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL nt%0d_pred_taken: got %0b want 0", i + 2, pred_taken); end
    end
    n_cmp++; if (cnt_hit !== exp_hit) begin n_err++; $display("FAIL nt_cnt_hit: got %h want %h", cnt_hit, exp_hit); end
    // 00 -> 01 -> 10 -> 11 -> 11 -> 11
    before_pred = 5'b11100;  // bit i: prediction before taken #i
    after_pred  = 5'b11110;  // bit i: prediction after taken #i
    for (int i = 0; i < 5; i++) begin
      ex_set(1'b1, 32'h10, 1'b1, 32'h40, before_pred[i], before_pred[i] ? 32'h40 : 32'h11);
      #1;
      n_cmp++; if (mispredict !== !before_pred[i]) begin n_err++; $display("FAIL tk%0d_mispredict: got %0b want %0b", i, mispredict, !before_pred[i]); end
      tick;
      exp_branch = exp_branch + 1;
      if (before_pred[i]) exp_hit = exp_hit + 1;
      n_cmp++; if (pred_taken !== after_pred[i]) begin n_err++; $display("FAIL tk%0d_pred_taken: got %0b want %0b", i, pred_taken, after_pred[i]); end
    end
    // 11 -> 10 still taken (proves saturation held at 11), then 10 -> 01
    ex_set(1'b1, 32'h10, 1'b0, 32'h40, 1'b1, 32'h40);
    tick;
    exp_branch = exp_branch + 1;
    n_cmp++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL sat_hi_pred_taken: got %0b want 1", pred_taken); end
    n_cmp++; if (pred_target !== 32'h40) begin n_err++; $display("FAIL sat_hi_pred_target: got %h want 00000040", pred_target); end
    ex_set(1'b1, 32'h10, 1'b0, 32'h40, 1'b1, 32'h40);
    tick;
    exp_branch = exp_branch + 1;
    n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL dec_wt_pred_taken: got %0b want 0", pred_taken); end
    n_cmp++; if (cnt_branch !== exp_branch) begin n_err++; $display("FAIL ctr_cnt_branch: got %h want %h", cnt_branch, exp_branch); end
    n_cmp++; if (cnt_hit !== exp_hit) begin n_err++; $display("FAIL ctr_cnt_hit: got %h want %h", cnt_hit, exp_hit); end
  endtask

  task automatic test_alias;
    ex_set(1'b1, 32'h18, 1'b1, 32'h80, 1'b0, 32'h19);
    #1;
    n_cmp++; if (mispredict !== 1'b1) begin n_err++; $display("FAIL alias_mispredict: got %0b want 1", mispredict); end
    tick;
    exp_branch = exp_branch + 1;
    pc_if = 32'h10;
    #1;
    n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL alias_old_pred_taken: got %0b want 0", pred_taken); end
    n_cmp++; if (pred_target !== 32'h11) begin n_err++; $display("FAIL alias_old_pred_target: got %h want 00000011", pred_target); end
    pc_if = 32'h18;
    #1;
    n_cmp++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL alias_new_pred_taken: got %0b want 1", pred_taken); end
    n_cmp++; if (pred_target !== 32'h80) begin n_err++; $display("FAIL alias_new_pred_target: got %h want 00000080", pred_target); end
  endtask

  task automatic test_wrong_target;
    ex_set(1'b1, 32'h18, 1'b1, 32'h50, 1'b1, 32'h40);
    #1;
    n_cmp++; if (mispredict !== 1'b1) begin n_err++; $display("FAIL wt_mispredict: got %0b want 1", mispredict); end
    n_cmp++; if (fix_pc !== 32'h50) begin n_err++; $display("FAIL wt_fix_pc: got %h want 00000050", fix_pc); end
    tick;
    exp_branch = exp_branch + 1;
    pc_if = 32'h18;
    #1;
    n_cmp++; if (pred_target !== 32'h50) begin n_err++; $display("FAIL wt_retarget: got %h want 00000050", pred_target); end
    // not-taken miss predicted not-taken: correct, table untouched
    ex_set(1'b1, 32'h20, 1'b0, 32'h99, 1'b0, 32'h21);
    #1;
    n_cmp++; if (mispredict !== 1'b0) begin n_err++; $display("FAIL ntnt_mispredict: got %0b want 0", mispredict); end
    n_cmp++; if (fix_pc !== 32'h21) begin n_err++; $display("FAIL ntnt_fix_pc: got %h want 00000021", fix_pc); end
    tick;
    exp_branch = exp_branch + 1;
    exp_hit    = exp_hit + 1;
    n_cmp++; if (cnt_hit !== exp_hit) begin n_err++; $display("FAIL ntnt_cnt_hit: got %h want %h", cnt_hit, exp_hit); end
    n_cmp++; if (cnt_branch !== exp_branch) begin n_err++; $display("FAIL ntnt_cnt_branch: got %h want %h", cnt_branch, exp_branch); end
    n_cmp++; if (pred_target !== 32'h50) begin n_err++; $display("FAIL ntnt_table_kept: got %h want 00000050", pred_target); end
  endtask

  task automatic test_halt;
    halt = 1'b1;
    ex_set(1'b1, 32'h30, 1'b1, 32'h99, 1'b0, 32'h31);
    #1;
    n_cmp++; if (mispredict !== 1'b0) begin n_err++; $display("FAIL halt_mispredict: got %0b want 0", mispredict); end
    tick;
    halt = 1'b0;
    n_cmp++; if (cnt_branch !== exp_branch) begin n_err++; $display("FAIL halt_cnt_branch: got %h want %h", cnt_branch, exp_branch); end
    n_cmp++; if (cnt_hit !== exp_hit) begin n_err++; $display("FAIL halt_cnt_hit: got %h want %h", cnt_hit, exp_hit); end
    pc_if = 32'h18;
    #1;
    n_cmp++; if (pred_target !== 32'h50) begin n_err++; $display("FAIL halt_keep_entry: got %h want 00000050", pred_target); end
    pc_if = 32'h30;
    #1;
    n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL halt_no_alloc: got %0b want 0", pred_taken); end
  endtask

  task automatic test_wrap;
    @(negedge clk);
    force dut.u_stats.cnt_branch_reg = 32'hFFFF_FFFE;
    force dut.u_stats.cnt_hit_reg    = 32'hFFFF_FFFF;
    #1;
    release dut.u_stats.cnt_branch_reg;
    release dut.u_stats.cnt_hit_reg;
    #1;
    n_cmp++; if (cnt_branch !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL wrap_preload: got %h want fffffffe", cnt_branch); end
    ex_set(1'b1, 32'h28, 1'b0, 32'h0, 1'b0, 32'h29);
    tick;
    n_cmp++; if (cnt_branch !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL wrap_branch_max: got %h want ffffffff", cnt_branch); end
    n_cmp++; if (cnt_hit !== 32'h0) begin n_err++; $display("FAIL wrap_hit_zero: got %h want 00000000", cnt_hit); end
    ex_set(1'b1, 32'h28, 1'b0, 32'h0, 1'b0, 32'h29);
    tick;
    n_cmp++; if (cnt_branch !== 32'h0) begin n_err++; $display("FAIL wrap_branch_zero: got %h want 00000000", cnt_branch); end
    n_cmp++; if (cnt_hit !== 32'h1) begin n_err++; $display("FAIL wrap_hit_one: got %h want 00000001", cnt_hit); end
  endtask

  task automatic test_midrun_reset;
    rst = 1'b1;
    ex_set(1'b1, 32'h11, 1'b1, 32'h77, 1'b0, 32'h12);
    tick;
    rst = 1'b0;
    exp_branch = 32'd0;
    exp_hit    = 32'd0;
    n_cmp++; if (cnt_branch !== exp_branch) begin n_err++; $display("FAIL mrst_cnt_branch: got %h want %h", cnt_branch, exp_branch); end
    n_cmp++; if (cnt_hit !== exp_hit) begin n_err++; $display("FAIL mrst_cnt_hit: got %h want %h", cnt_hit, exp_hit); end
    pc_if = 32'h18;
    #1;
    n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL mrst_cleared: got %0b want 0", pred_taken); end
    n_cmp++; if (pred_target !== 32'h19) begin n_err++; $display("FAIL mrst_cleared_target: got %h want 00000019", pred_target); end
    pc_if = 32'h11;
    #1;
    n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL mrst_discard_train: got %0b want 0", pred_taken); end
  endtask

  initial begin
    rst            = 1'b1;
    halt           = 1'b0;
    pc_if          = 32'h0;
    ex_valid       = 1'b0;
    ex_pc          = 32'h0;
    ex_taken       = 1'b0;
    ex_target      = 32'h0;
    ex_pred_taken  = 1'b0;
    ex_pred_target = 32'h0;
    test_reset;
    test_allocate;
    test_counter;
    test_alias;
    test_wrong_target;
    test_halt;
    test_wrap;
    test_midrun_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Safety net in case the run stalls.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
